// File: rtl/core_bus_arbiter_if.sv
// Memory-port bundle between the core, a DMA requester, the memory decoder and the arbiter.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface core_bus_arbiter_if;
  logic [31:0] cpu_a;
  logic [31:0] cpu_o;
  logic [1:0]  cpu_ws;
  logic        cpu_w;
  logic [31:0] cpu_i;
  logic        cpu_ce;

  logic        dma_req;
  logic [31:0] dma_a;
  logic [31:0] dma_o;
  logic [1:0]  dma_ws;
  logic        dma_w;
  logic [31:0] dma_i;
  logic        dma_ack;

  logic [31:0] mem_a;
  logic [31:0] mem_o;
  logic [1:0]  mem_ws;
  logic        mem_w;
  logic [31:0] mem_i;

  modport slave (
    input  cpu_a, cpu_o, cpu_ws, cpu_w,
    output cpu_i, cpu_ce,
    input  dma_req, dma_a, dma_o, dma_ws, dma_w,
    output dma_i, dma_ack,
    output mem_a, mem_o, mem_ws, mem_w,
    input  mem_i
  );

  modport master (
    output cpu_a, cpu_o, cpu_ws, cpu_w,
    input  cpu_i, cpu_ce,
    output dma_req, dma_a, dma_o, dma_ws, dma_w,
    input  dma_i, dma_ack,
    input  mem_a, mem_o, mem_ws, mem_w,
    output mem_i
  );
endinterface

// File: rtl/core_bus_arbiter.sv
// Shares one memory port between the core and a DMA requester; the core is frozen via
// cpu_ce while DMA owns the bus. Bursts are capped at BURST, followed by CPU_SLICE CPU cycles.
module core_bus_arbiter #(
  parameter int unsigned BURST     = 4,
  parameter int unsigned CPU_SLICE = 2
) (
  input  logic                clock,
  input  logic                reset,
  core_bus_arbiter_if.slave   bus,
  output logic [15:0]         stall_cnt
);

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } own_t;

  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);
  localparam logic [7:0] SLICE_LOAD = 8'(CPU_SLICE - 1);

  own_t        own_q, own_d;
  logic [7:0]  burst_q, burst_d;
  logic [7:0]  slice_q, slice_d;
  logic [15:0] stall_q, stall_d;
  logic        dma_own;

  // Reset forces CPU ownership combinationally so a mid-burst reset drops the transfer unacked.
  assign dma_own = (own_q == OWN_DMA) && !reset;

  assign bus.cpu_ce  = !dma_own && !reset;
  assign bus.dma_ack = dma_own && bus.dma_req;
  assign bus.mem_a   = dma_own ? bus.dma_a  : bus.cpu_a;
  assign bus.mem_o   = dma_own ? bus.dma_o  : bus.cpu_o;
  assign bus.mem_ws  = dma_own ? bus.dma_ws : bus.cpu_ws;
  assign bus.mem_w   = dma_own ? (bus.dma_w && bus.dma_req) : (bus.cpu_w && !reset);
  assign bus.cpu_i   = bus.mem_i;
  assign bus.dma_i   = bus.mem_i;
  assign stall_cnt   = stall_q;

  always_comb begin
    own_d   = own_q;
    burst_d = burst_q;
    slice_d = slice_q;
    unique case (own_q)
      OWN_CPU: begin
        if (slice_q != '0) begin
          slice_d = slice_q - 8'd1;
        end else if (bus.dma_req) begin
          own_d   = OWN_DMA;
          burst_d = '0;
        end
      end
      OWN_DMA: begin
        if ((burst_q == BURST_LAST) || !bus.dma_req) begin
          own_d   = OWN_CPU;
          slice_d = SLICE_LOAD;
        end else begin
          burst_d = burst_q + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (!bus.cpu_ce && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      own_q   <= OWN_CPU;
      burst_q <= '0;
      slice_q <= '0;
      stall_q <= '0;
    end else begin
      own_q   <= own_d;
      burst_q <= burst_d;
      slice_q <= slice_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Self-checking bench for core_bus_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against an elapsed-cycle ownership model; a second instance covers saturation.
module tb_core_bus_arbiter;
  localparam int BA = 4;
  localparam int SA = 2;
  localparam int BB = 255;
  localparam int SB = 1;

  logic        clock = 1'b0;
  logic        ra, rb;
  logic [15:0] stall_a, stall_b;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wr80 = 0;
  logic [31:0] mem [0:255];

  core_bus_arbiter_if ifa ();
  core_bus_arbiter_if ifb ();

  core_bus_arbiter #(.BURST(BA), .CPU_SLICE(SA)) dut_a (
    .clock(clock), .reset(ra), .bus(ifa), .stall_cnt(stall_a)
  );
  core_bus_arbiter #(.BURST(BB), .CPU_SLICE(SB)) dut_b (
    .clock(clock), .reset(rb), .bus(ifb), .stall_cnt(stall_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Memory behind instance A: same-cycle read, write at the rising edge
  assign ifa.mem_i = mem[ifa.mem_a[9:2]];
  assign ifb.mem_i = '0;

  always @(posedge clock) begin
    if (ifa.mem_w) begin
      case (ifa.mem_ws)
        2'd3:    mem[ifa.mem_a[9:2]] <= ifa.mem_o;
        2'd1:    mem[ifa.mem_a[9:2]][ifa.mem_a[1]*16 +: 16] <= ifa.mem_o[15:0];
        default: mem[ifa.mem_a[9:2]][ifa.mem_a[1:0]*8 +: 8] <= ifa.mem_o[7:0];
      endcase
      if (ifa.mem_a == 32'h80) wr80 <= wr80 + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  // Reference model A: ownership from elapsed-cycle counts of the current CPU/DMA run
  bit          m_dma = 1'b0;
  int          m_cpu_run = SA;
  int          m_dma_run = 0;
  int          m_stall = 0;
  // Reference model B: sustained request gives a fixed period after reset release
  int          nb = 0;
  int          sb = 0;

  always @(negedge clock) begin
    bit          e_dma, e_dmab;
    logic [31:0] e_a;
    int          run;
    e_dma = m_dma && !ra;
    e_a   = e_dma ? ifa.dma_a : ifa.cpu_a;
    chk("cpu_ce", ifa.cpu_ce, !e_dma && !ra);
    chk("dma_ack", ifa.dma_ack, e_dma && ifa.dma_req);
    chk("mem_a", ifa.mem_a, e_a);
    chk("mem_o", ifa.mem_o, e_dma ? ifa.dma_o : ifa.cpu_o);
    chk("mem_ws", ifa.mem_ws, e_dma ? ifa.dma_ws : ifa.cpu_ws);
    chk("mem_w", ifa.mem_w, e_dma ? (ifa.dma_w && ifa.dma_req) : (ifa.cpu_w && !ra));
    chk("cpu_i", ifa.cpu_i, mem[e_a[9:2]]);
    chk("dma_i", ifa.dma_i, mem[e_a[9:2]]);
    chk("stall_cnt", stall_a, m_stall);
    if (ra) begin
      m_dma = 1'b0; m_cpu_run = SA; m_dma_run = 0; m_stall = 0;
    end else if (!m_dma) begin
      run = (m_cpu_run + 1 > SA) ? SA : m_cpu_run + 1;
      if (run >= SA && ifa.dma_req) begin
        m_dma = 1'b1; m_dma_run = 0;
      end else begin
        m_cpu_run = run;
      end
    end else begin
      if (m_stall < 65535) m_stall = m_stall + 1;
      run = m_dma_run + 1;
      if (!ifa.dma_req || run >= BA) begin
        m_dma = 1'b0; m_cpu_run = 0;
      end else begin
        m_dma_run = run;
      end
    end

    if (rb) begin
      chk("b_rst_ce", ifb.cpu_ce, 1'b0);
      nb = 0; sb = 0;
    end else begin
      e_dmab = (nb >= 1) && (((nb - 1) % (BB + SB)) < BB);
      chk("b_cpu_ce", ifb.cpu_ce, !e_dmab);
      chk("b_dma_ack", ifb.dma_ack, e_dmab);
      chk("b_stall_cnt", stall_b, sb);
      if (e_dmab && sb < 65535) sb = sb + 1;
      nb = nb + 1;
    end
  end

  logic [19:0] pat = 20'b1111_0011_1100_1111_0011;

  initial begin
    bit done, got_ack, stalled, req, ack;
    int phase, t1, t2, ce_between, acks;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[64] = 32'h1234_5678;
    ifa.cpu_a = '0; ifa.cpu_o = '0; ifa.cpu_ws = 2'd3; ifa.cpu_w = 1'b1;
    ifa.dma_a = '0; ifa.dma_o = '0; ifa.dma_ws = 2'd3; ifa.dma_w = 1'b0; ifa.dma_req = 1'b1;
    ifb.cpu_a = '0; ifb.cpu_o = '0; ifb.cpu_ws = '0; ifb.cpu_w = 1'b0;
    ifb.dma_a = '0; ifb.dma_o = '0; ifb.dma_ws = '0; ifb.dma_w = 1'b0; ifb.dma_req = 1'b1;
    ra = 1'b1; rb = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_cpu_ce", ifa.cpu_ce, 1'b0);
      chk("rst_dma_ack", ifa.dma_ack, 1'b0);
      chk("rst_mem_w", ifa.mem_w, 1'b0);
    end
    nxt();
    ra = 1'b0; rb = 1'b0; ifa.cpu_w = 1'b0;

    // Sustained request straight out of reset
    for (int k = 0; k < 22; k++) begin
      @(negedge clock);
      if (k == 0) begin
        chk("first_cpu_ce", ifa.cpu_ce, 1'b1);
        chk("first_dma_ack", ifa.dma_ack, 1'b0);
      end else if (k <= 20) begin
        chk("burst_ack_pat", ifa.dma_ack, pat[20-k]);
        chk("burst_ce_pat", ifa.cpu_ce, !pat[20-k]);
      end else begin
        chk("burst_stall_sum", stall_a, 16'd14);
      end
    end
    nxt();
    ifa.dma_req = 1'b0;
    repeat (4) nxt();

    // Core store stalled behind a DMA read of 0x100
    ifa.dma_a = 32'h100; ifa.dma_w = 1'b0; ifa.dma_req = 1'b1;
    nxt();
    ifa.cpu_a = 32'h80; ifa.cpu_o = 32'hCAFE_F00D; ifa.cpu_ws = 2'd3; ifa.cpu_w = 1'b1;
    done = 1'b0; got_ack = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clock);
      if (ifa.dma_ack) begin
        chk("stall_dma_i", ifa.dma_i, 32'h1234_5678);
        got_ack = 1'b1;
      end
      stalled = !ifa.cpu_ce;
      if (stalled) chk("stall_mem_w", ifa.mem_w, 1'b0);
      nxt();
      if (got_ack) ifa.dma_req = 1'b0;
      if (!stalled) begin
        ifa.cpu_w = 1'b0; done = 1'b1;
      end
    end
    chk("store_done", done, 1'b1);
    chk("store_dma_ack", got_ack, 1'b1);
    repeat (3) @(negedge clock);
    chk("store_once", wr80, 1);
    chk("store_data", mem[32], 32'hCAFE_F00D);

    // DMA word write then core load of the same address
    repeat (3) nxt();
    ifa.dma_a = 32'h40; ifa.dma_o = 32'hDEAD_BEEF; ifa.dma_ws = 2'd3; ifa.dma_w = 1'b1;
    ifa.dma_req = 1'b1;
    got_ack = 1'b0;
    for (int c = 0; c < 10 && !got_ack; c++) begin
      @(negedge clock);
      if (ifa.dma_ack) got_ack = 1'b1;
      nxt();
      if (got_ack) begin ifa.dma_req = 1'b0; ifa.dma_w = 1'b0; end
    end
    chk("dmaw_ack", got_ack, 1'b1);
    ifa.cpu_a = 32'h40; ifa.cpu_w = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clock);
      if (ifa.cpu_ce) begin
        chk("lw_data", ifa.cpu_i, 32'hDEAD_BEEF);
        done = 1'b1;
      end
      nxt();
    end
    chk("lw_done", done, 1'b1);

    // Two single-transfer requests separated by one idle cycle
    repeat (4) nxt();
    ifa.dma_a = 32'h100; ifa.dma_w = 1'b0; ifa.dma_req = 1'b1;
    phase = 0; t1 = -1; t2 = -1; ce_between = 0; acks = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (ifa.dma_ack) begin
        acks++;
        if (t1 < 0) t1 = c; else t2 = c;
      end else if (t1 >= 0 && t2 < 0 && ifa.cpu_ce) begin
        ce_between++;
      end
      nxt();
      if (phase == 0 && t1 >= 0) begin ifa.dma_req = 1'b0; phase = 1; end
      else if (phase == 1) begin ifa.dma_req = 1'b1; phase = 2; end
      else if (phase == 2 && t2 >= 0) begin ifa.dma_req = 1'b0; phase = 3; end
    end
    chk("pulse_grant_lat", t1, 1);
    chk("pulse_ack_count", acks, 2);
    chk("pulse_spacing", t2 - t1, 4);
    chk("pulse_cpu_slice", ce_between, SA);

    // Randomized traffic, including resets during bursts
    while (cyc < 66100) begin
      @(negedge clock);
      req = ifa.dma_req; ack = ifa.dma_ack;
      nxt();
      ra = ($urandom_range(0, 149) == 0);
      ifa.cpu_a  = $urandom; ifa.cpu_o = $urandom;
      ifa.cpu_ws = 2'($urandom_range(0, 3)); ifa.cpu_w = 1'($urandom_range(0, 1));
      if (req && !ack) begin
        ifa.dma_req = ($urandom_range(0, 15) != 0);
      end else begin
        ifa.dma_req = ($urandom_range(0, 2) != 0);
        ifa.dma_a  = $urandom; ifa.dma_o = $urandom;
        ifa.dma_ws = 2'($urandom_range(0, 3)); ifa.dma_w = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clock);
    chk("b_stall_saturated", stall_b, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_bus_arbiter.md
# core_bus_arbiter

Shares the single memory port between the RISC-V core and a DMA requester, such as the video fetcher or a loader. The core has no wait input. The arbiter therefore freezes it with `cpu_ce` on any cycle the DMA owns memory, and the core resumes with its state intact. The block sits between `core` and the memory/peripheral decoder. It owns bus ownership, the DMA burst length, the CPU minimum time-slice, and a stall statistic.

## Interface
- `BURST`, default 4: maximum consecutive DMA-owned cycles. Legal range is 1..255.
- `CPU_SLICE`, default 2: CPU-owned cycles guaranteed after every DMA burst. Legal range is 1..255.
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `cpu_a`  in  32: core address.
- `cpu_o`  in  32: core write data.
- `cpu_ws`  in  2: core write size (0=1 B, 1=2 B, 3=4 B).
- `cpu_w`  in  1: core write strobe.
- `cpu_i`  out  32: read data to the core; equals `mem_i`.
- `cpu_ce`  out  1: core clock enable; 1 only on CPU-owned cycles.
- `dma_req`  in  1: DMA wants a transfer this cycle. The requester holds `dma_a`/`dma_o`/`dma_w`/`dma_ws` stable while `dma_req` is high and `dma_ack` is low.
- `dma_a`  in  32: DMA address.
- `dma_o`  in  32: DMA write data.
- `dma_ws`  in  2: DMA write size.
- `dma_w`  in  1: DMA write strobe.
- `dma_i`  out  32: read data to DMA; equals `mem_i`.
- `dma_ack`  out  1: the transfer completes this cycle; read data is valid and a write commits at this rising edge.
- `mem_a`  out  32: memory address.
- `mem_o`  out  32: memory write data.
- `mem_ws`  out  2: memory write size.
- `mem_w`  out  1: memory write strobe.
- `mem_i`  in  32: memory read data, valid in the same cycle as `mem_a` (combinational or negedge-clocked read).
- `stall_cnt`  out  16: count of cycles with `cpu_ce`=0 since reset; saturates at 16'hFFFF.

## Operation
- State register `own`: CPU or DMA. Counters: `burst_cnt` and `slice_cnt`, 8-bit each.
- Mux (combinational from `own`):
  - CPU state: `mem_a/o/ws` = `cpu_*` and `mem_w` = `cpu_w`.
  - DMA state: `mem_a/o/ws` = `dma_*` and `mem_w` = `dma_w & dma_req`.
- Core write gating: the core holds `w` high across a stalled cycle, so `cpu_w` never reaches `mem_w` in DMA state.
- `cpu_ce` = (`own`==CPU) & ~`reset`.
- `dma_ack` = (`own`==DMA) & `dma_req`.
- CPU state transitions:
  - `slice_cnt`≠0: decrement.
  - `slice_cnt`==0 and `dma_req`=1: go to DMA and load `burst_cnt`=0.
  - Otherwise stay in CPU.
- DMA state transitions:
  - `burst_cnt`==`BURST`-1, or `dma_req`=0: go to CPU and load `slice_cnt`=`CPU_SLICE`-1.
  - Otherwise increment `burst_cnt`.
- Empty DMA cycle: `dma_req` dropping while in DMA state costs one cycle. `cpu_ce` is 0 and nothing is transferred; the arbiter returns to CPU on the next cycle.
- Mid-instruction steals are legal between the two phases of a LOAD/STORE, because the core is fully frozen by `cpu_ce`.
- `stall_cnt` increments on every non-reset cycle with `cpu_ce`=0 and holds at 16'hFFFF.

## Timing
- Reset values:
  - `own`=CPU, `slice_cnt`=0, `burst_cnt`=0, `stall_cnt`=0.
  - During reset: `cpu_ce`=0, `dma_ack`=0, and the `mem_*` outputs follow CPU ownership.
  - `mem_w` = `cpu_w` & ~`reset` and is therefore 0 during reset.
- Reset asserted mid-burst: the next cycle is CPU-owned with all counters cleared, and any in-flight DMA transfer is dropped without ack.
- DMA grant latency from `dma_req` rising in CPU state with `slice_cnt`==0: one cycle. The first `dma_ack` is in the following cycle.
- Worst-case DMA wait: `CPU_SLICE`+1 cycles. Worst-case CPU stall: `BURST` cycles.
- Sustained `dma_req`: the period is `BURST` DMA cycles plus `CPU_SLICE` CPU cycles. With defaults: 4 ack cycles, then 2 CPU cycles, repeating.
- `BURST`=1 alternates DMA/CPU with `CPU_SLICE` spacing.
- All outputs except `stall_cnt` are combinational from registered state and inputs; there is no added bus latency on CPU cycles.

## Test plan
- Reset for 3 cycles with `dma_req`=1 and `cpu_w`=1 -> `cpu_ce`=0, `dma_ack`=0 and `mem_w`=0 throughout; after release, the first cycle has `cpu_ce`=1 and the next has `dma_ack`=1.
- `dma_req` held high for 20 cycles with defaults -> `dma_ack` pattern 1111 00 1111 00 …; `cpu_ce` is exactly its complement; `stall_cnt` equals the number of ack cycles.
- Core STORE with `w`=1 stalled by a DMA read of 0x100 -> `mem_w`=0 during the DMA cycles; the core's write to its address commits exactly once, after `cpu_ce` returns; `dma_i` returns the word at 0x100.
- DMA writes 0xDEADBEEF to 0x40 (`ws`=3), then the core executes LW from 0x40 -> the core reads 0xDEADBEEF.
- A single-cycle `dma_req` pulse -> exactly one `dma_ack`, then ownership returns to CPU; a second pulse is not granted until `CPU_SLICE` CPU cycles have elapsed.
- Force the stall count to saturation (stall for 65,540 cycles) -> `stall_cnt` holds 16'hFFFF.
